main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
- Memory-side responder for the cache line-fill interface: accepts block read and block write requests and serves 4-word bursts from a word-addressed backing store.
- Sits between the cache miss/writeback logic and the main-memory model. Used as the behavioural main memory in the cache bench and as the template for the real memory controller front end.
- Reads are returned critical-word-first with wrap-around inside the block.

Parameters:
- WORD_WIDTH, 64, data word width in bits.
- BLOCK_WORDS, 4, words per burst; power of two.
- ADDR_WIDTH, 32, request byte-address width.
- MEM_DEPTH_WORDS, 4096, backing store depth in words; power of two.
- READ_LATENCY, 3, cycles from request acceptance edge to first read beat; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = block write, 0 = block read; sampled on acceptance.
- req_addr  input  ADDR_WIDTH  byte address; sampled on acceptance.
- wr_data  input  WORD_WIDTH  write beat data.
- wr_valid  input  1  write beat present.
- wr_ready  output  1  responder accepts a write beat.
- rd_data  output  WORD_WIDTH  read beat data.
- rd_valid  output  1  read beat valid; no backpressure.
- rd_last  output  1  final beat of a read burst.
- err  output  1  high on every beat of an out-of-range burst.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: req_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, err=0, busy=0, state IDLE, latency counter 0, beat counter 0.
- Backing store is not cleared by reset.
- Address decode:
  - word index = req_addr >> 3.
  - block base = word index with low log2(BLOCK_WORDS) bits cleared.
  - start word = req_addr[4:3].
  - req_addr[2:0] is ignored.
  - Out of range when word index >= MEM_DEPTH_WORDS.
- Acceptance: on an edge where req_valid && req_ready, capture req_write, base, start word and the range flag. req_ready is high only in IDLE.
- States and transitions:
  - IDLE -> LAT on an accepted read.
  - IDLE -> WR_BURST on an accepted write.
  - LAT: count down from READ_LATENCY-1. Enter RD_BURST when the count reaches 0. With READ_LATENCY=1, go directly IDLE -> RD_BURST.
  - RD_BURST: BLOCK_WORDS consecutive cycles with rd_valid=1. Beat k carries word base + ((start + k) mod BLOCK_WORDS).
    - rd_last=1 on beat BLOCK_WORDS-1 only.
    - Then return to IDLE; req_ready is high in the next cycle.
  - WR_BURST: wr_ready=1. Each edge with wr_valid && wr_ready writes wr_data to base + beat, with beat incrementing 0..BLOCK_WORDS-1 in order. Writes always start at word 0 regardless of the start word.
    - Cycles with wr_valid=0 stall; there is no timeout.
    - After the last beat is written, return to IDLE.
- Timing: the first read beat is visible in the cycle following the READ_LATENCY-th rising edge after the acceptance edge. Total read occupancy is READ_LATENCY + BLOCK_WORDS cycles.
- Out of range:
  - Read: burst timing is unchanged, rd_data=0 and err=1 on every beat.
  - Write: beats are consumed and discarded, err=1 while in WR_BURST.
- Read-after-write: a read accepted after a write burst completes returns the newly written data. There is no bypass hazard, because the write completes before IDLE.
- Simultaneous events:
  - req_valid while busy is held off by req_ready=0; the requester must keep it stable.
  - wr_valid outside WR_BURST is ignored.
- Reset mid-operation: the burst is abandoned immediately and outputs take their reset values. Words already written stay written; partial write bursts are not rolled back.
- rd_data holds its last value when rd_valid=0; consumers must not sample it then.

Test Plan:
- Reset, write block at 0x0000_0100 with words 0xA0..0xA3, then read at 0x0000_0100 -> with READ_LATENCY=3, rd_valid rises 3 cycles after acceptance; data 0xA0,0xA1,0xA2,0xA3; rd_last on beat 4; req_ready back the next cycle.
- Read at 0x0000_0110 (start word 2) of the same block -> beats 0xA2,0xA3,0xA0,0xA1, verifying wrap-around; err=0.
- Write burst with wr_valid deasserted for 2 cycles between beats 1 and 2 -> wr_ready stays high, only 4 words are written, and a subsequent read matches.
- Read at byte address MEM_DEPTH_WORDS*8 -> 4 beats of rd_data=0 with err=1; busy drops after 7 cycles.
- Assert reset during beat 2 of a read -> rd_valid=0, req_ready=1 asynchronously. A new read after reset returns the correct, unmodified data.
- req_valid held high while busy -> exactly one acceptance per burst, with no request accepted during the LAT or RD_BURST states.

Source files
------------

// File: rtl/main_memory_responder.sv
// ---------------------------------------------------------------------------
// main_memory_responder
//
// Memory-side responder for the cache line-fill interface. Accepts block
// read and block write requests and moves BLOCK_WORDS-word bursts to and
// from a word-addressed backing store. Reads come back critical-word-first,
// wrapping inside the block. Writes always fill the block from word 0.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid_i  request present
//   req_ready_o  responder can accept a request (IDLE only)
//   req_write_i  1 = block write, 0 = block read (sampled on acceptance)
//   req_addr_i   byte address (sampled on acceptance)
//   wr_data_i    write beat data
//   wr_valid_i   write beat present
//   wr_ready_o   responder accepts a write beat (WR_BURST only)
//   rd_data_o    read beat data, holds its value between bursts
//   rd_valid_o   read beat valid, no backpressure
//   rd_last_o    final beat of a read burst
//   err_o        high on every beat of an out-of-range burst
//   busy_o       high whenever the responder is not IDLE
// ---------------------------------------------------------------------------
module main_memory_responder #(
  parameter int WORD_WIDTH      = 64,
  parameter int BLOCK_WORDS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 4096,
  parameter int READ_LATENCY    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_last_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int LOG_BW = $clog2(BLOCK_WORDS);
  localparam int MEM_AW = $clog2(MEM_DEPTH_WORDS);
  localparam int WI_W   = ADDR_WIDTH - 3;
  localparam int BASE_W = MEM_AW - LOG_BW;

  localparam logic [3:0]        LAT_INIT  = 4'(READ_LATENCY - 1);
  localparam logic [LOG_BW-1:0] LAST_BEAT = LOG_BW'(BLOCK_WORDS - 1);
  localparam logic [WI_W-1:0]   DEPTH_IDX = WI_W'(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAT,
    S_RD_BURST,
    S_WR_BURST
  } state_e;

  // Backing store.
  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  // State and captured request.
  state_e                state_q,   state_d;
  logic [3:0]            lat_q,     lat_d;
  logic [LOG_BW-1:0]     beat_q,    beat_d;
  logic [BASE_W-1:0]     base_q,    base_d;
  logic [LOG_BW-1:0]     start_q,   start_d;
  logic                  oor_q,     oor_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;

  // Request decode. The byte offset within a word carries no information.
  logic [WI_W-1:0]   req_word_idx;
  logic [BASE_W-1:0] req_base;
  logic [LOG_BW-1:0] req_start;
  logic              req_oor;
  logic              unused_addr_bits;

  assign req_word_idx     = req_addr_i[ADDR_WIDTH-1:3];
  assign req_base         = req_word_idx[MEM_AW-1:LOG_BW];
  assign req_start        = req_word_idx[LOG_BW-1:0];
  assign req_oor          = (req_word_idx >= DEPTH_IDX);
  assign unused_addr_bits = ^req_addr_i[2:0];

  // Read-word selection. With READ_LATENCY=1 the first beat is fetched on
  // the acceptance edge itself, so the freshly decoded request must be used
  // instead of the (not yet loaded) captured copy.
  logic              load_rd;
  logic [BASE_W-1:0] sel_base;
  logic [LOG_BW-1:0] sel_start;
  logic              sel_oor;
  logic [LOG_BW-1:0] rd_off;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    base_d    = base_q;
    start_d   = start_q;
    oor_d     = oor_q;
    load_rd   = 1'b0;
    sel_base  = base_q;
    sel_start = start_q;
    sel_oor   = oor_q;

    unique case (state_q)
      S_IDLE: begin
        sel_base  = req_base;
        sel_start = req_start;
        sel_oor   = req_oor;
        if (req_valid_i) begin
          base_d  = req_base;
          start_d = req_start;
          oor_d   = req_oor;
          beat_d  = '0;
          if (req_write_i) begin
            state_d = S_WR_BURST;
          end else if (READ_LATENCY == 1) begin
            state_d = S_RD_BURST;
            load_rd = 1'b1;
          end else begin
            state_d = S_LAT;
            lat_d   = LAT_INIT;
          end
        end
      end

      S_LAT: begin
        if (lat_q == 4'd0) begin
          state_d = S_RD_BURST;
          beat_d  = '0;
          load_rd = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      S_RD_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 1'b1;
          load_rd = 1'b1;
        end
      end

      S_WR_BURST: begin
        if (wr_valid_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Beat k of a read carries word (start + k) mod BLOCK_WORDS of the block;
  // the LOG_BW-bit add wraps naturally.
  assign rd_off = sel_start + beat_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (load_rd) begin
      rd_data_d = sel_oor ? '0 : mem[{sel_base, rd_off}];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its D input from before the edge, independent of block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      start_q   <= '0;
      oor_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      start_q   <= start_d;
      oor_q     <= oor_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the backing store has no reset; clearing it would need one write
  // per word, and its contents are expected to survive a controller reset.
  always_ff @(posedge clock) begin
    if (state_q == S_WR_BURST && wr_valid_i && !oor_q) begin
      mem[{base_q, beat_q}] <= wr_data_i;
    end
  end

  // Outputs decode directly from state, so an asynchronous reset forces
  // them to their idle values without waiting for a clock edge.
  assign req_ready_o = (state_q == S_IDLE);
  assign wr_ready_o  = (state_q == S_WR_BURST);
  assign rd_valid_o  = (state_q == S_RD_BURST);
  assign rd_last_o   = (state_q == S_RD_BURST) && (beat_q == LAST_BEAT);
  assign err_o       = oor_q && ((state_q == S_RD_BURST) || (state_q == S_WR_BURST));
  assign busy_o      = (state_q != S_IDLE);
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_main_memory_responder
//
// Directed bench for main_memory_responder with default parameters
// (64-bit words, 4-word blocks, 4096-word store, READ_LATENCY=3).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_main_memory_responder;

  localparam int RL = 3;

  typedef logic [63:0] blk_t [4];

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  main_memory_responder dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .wr_data_i   (wr_data),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rd_last_o   (rd_last),
    .err_o       (err),
    .busy_o      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input blk_t d,
                          input int stall_after, input int stall_cycles);
    check({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s wr_ready b%0d", tag, k), wr_ready, 1);
      check($sformatf("%s busy b%0d", tag, k), busy, 1);
      wr_valid = 1'b1;
      wr_data  = d[k];
      tick();
      wr_valid = 1'b0;
      wr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      if (k == stall_after) begin
        for (int s = 0; s < stall_cycles; s++) begin
          check($sformatf("%s stall wr_ready s%0d", tag, s), wr_ready, 1);
          tick();
        end
      end
    end
    check({tag, " done wr_ready"}, wr_ready, 0);
    check({tag, " done req_ready"}, req_ready, 1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input blk_t exp,
                         input logic exp_err);
    check({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < RL; i++) begin
      check($sformatf("%s lat rd_valid c%0d", tag, i), rd_valid, 0);
      check($sformatf("%s lat req_ready c%0d", tag, i), req_ready, 0);
      check($sformatf("%s lat busy c%0d", tag, i), busy, 1);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s rd_valid b%0d", tag, k), rd_valid, 1);
      check($sformatf("%s rd_data b%0d", tag, k), rd_data, exp[k]);
      check($sformatf("%s rd_last b%0d", tag, k), rd_last, (k == 3));
      check($sformatf("%s err b%0d", tag, k), err, exp_err);
      check($sformatf("%s busy b%0d", tag, k), busy, 1);
      tick();
    end
    check({tag, " end rd_valid"}, rd_valid, 0);
    check({tag, " end req_ready"}, req_ready, 1);
    check({tag, " end busy"}, busy, 0);
  endtask

  initial begin
    blk_t blk_a, blk_a_rot2, blk_b, blk_c, blk_zero, blk_a_rot0;
    int   acc;
    int   beats;

    blk_a      = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    blk_a_rot0 = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    blk_a_rot2 = '{64'hA2, 64'hA3, 64'hA0, 64'hA1};
    blk_b      = '{64'h1111_0000_0000_00B0, 64'h2222_0000_0000_00B1,
                   64'h3333_0000_0000_00B2, 64'h4444_0000_0000_00B3};
    blk_c      = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
    blk_zero   = '{64'h0, 64'h0, 64'h0, 64'h0};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;

    // Reset values while reset is held.
    #2;
    check("rst req_ready", req_ready, 1);
    check("rst wr_ready", wr_ready, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_last", rd_last, 0);
    check("rst rd_data", rd_data, 0);
    check("rst err", err, 0);
    check("rst busy", busy, 0);
    #10;
    reset = 1'b1;
    tick();

    // wr_valid outside WR_BURST must not move the responder.
    wr_valid = 1'b1;
    wr_data  = 64'h5555;
    tick();
    wr_valid = 1'b0;
    check("stray wr busy", busy, 0);

    // Basic write then aligned read, and a wrapped read from start word 2.
    do_write("wrA", 32'h0000_0100, blk_a, -1, 0);
    do_read("rdA", 32'h0000_0100, blk_a, 1'b0);
    do_read("rdA_wrap", 32'h0000_0110, blk_a_rot2, 1'b0);

    // Neighbour block, then a stalled write into 0x200; the neighbour at
    // 0x220 must be untouched by the stalled burst.
    do_write("wrC", 32'h0000_0220, blk_c, -1, 0);
    do_write("wrB_stall", 32'h0000_0200, blk_b, 1, 2);
    do_read("rdB", 32'h0000_0200, blk_b, 1'b0);
    do_read("rdC", 32'h0000_0220, blk_c, 1'b0);

    // Out-of-range read: first word index past the store.
    do_read("rd_oor", 32'h0000_8000, blk_zero, 1'b1);

    // Reset in the middle of a read, on beat 2.
    check("mid req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0100;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < RL + 2; i++) tick();
    check("mid beat2 rd_data", rd_data, 64'hA2);
    check("mid beat2 rd_valid", rd_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid rst rd_valid", rd_valid, 0);
    check("mid rst req_ready", req_ready, 1);
    check("mid rst busy", busy, 0);
    check("mid rst rd_last", rd_last, 0);
    check("mid rst rd_data", rd_data, 0);
    #2;
    reset = 1'b1;
    tick();
    do_read("rd_after_rst", 32'h0000_0110, blk_a_rot2, 1'b0);

    // req_valid held for a full read occupancy: only one acceptance.
    acc   = 0;
    beats = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0100;
    for (int c = 0; c < RL + 4 + 1; c++) begin
      if (c == RL + 4) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
      if (rd_valid) beats++;
      tick();
    end
    req_valid = 1'b0;
    check("held acceptances", 64'(acc), 64'd1);
    check("held beats", 64'(beats), 64'd4);
    check("held idle", busy, 0);
    do_read("rd_final", 32'h0000_0100, blk_a_rot0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
